// File: rtl/tx_ctrl_pkg.sv
// Shared transmit-control definitions: FSM state encoding and the framing constants
// that the receiver sync logic must match bit for bit.
package tx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_LEN  = 3'd2,
        ST_PAY  = 3'd3,
        ST_PAR  = 3'd4,
        ST_TAIL = 3'd5
    } tx_state_e;

    localparam int         TX_PRE_LEN   = 8;
    localparam logic [7:0] TX_PRE_PAT   = 8'b1010_1011;
    localparam int         TX_TAIL_BITS = 2;

    function automatic int tx_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period divider: counts 0..BIT_DIV-1 while a frame runs and strobes bit_en_o
// in the last cycle of every bit period.
module tx_bit_timer #(
    parameter int BIT_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic bit_en_o
);

    localparam int            CW  = $clog2(BIT_DIV);
    localparam logic [CW-1:0] TOP = CW'(BIT_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (cnt_q == TOP) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_en_o = run_i && (cnt_q == TOP);

endmodule

// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: serialises preamble, length, payload, parity and flush
// tail into the encoder input, one bit per BIT_DIV clocks.
module tx_frame_sequencer
    import tx_ctrl_pkg::*;
#(
    parameter int                 DATA_W    = 8,
    parameter int                 LEN_W     = 4,
    parameter int                 BIT_DIV   = 16,
    parameter int                 PRE_LEN   = TX_PRE_LEN,
    parameter logic [PRE_LEN-1:0] PRE_PAT   = PRE_LEN'(TX_PRE_PAT),
    parameter int                 TAIL_BITS = TX_TAIL_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              bit_o,
    output logic              bit_en,
    output logic              enc_reset,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    // One MSB-aligned shift register serves preamble, length and payload fields.
    localparam int SH_W  = tx_max(tx_max(PRE_LEN, LEN_W), DATA_W);
    localparam int MAXF  = tx_max(SH_W, TAIL_BITS);
    localparam int CNT_W = tx_max(1, $clog2(MAXF));

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  fetched_q, fetched_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic              wbuf_full_q, wbuf_full_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic              par_q, par_d;
    logic              bit_q, bit_d;

    logic start_acc;
    logic last_bit;
    logic field_end;
    logic final_word;
    logic boundary;
    logic load;
    logic shifting;

    tx_bit_timer #(
        .BIT_DIV (BIT_DIV)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (start_acc),
        .run_i    (state_q != ST_IDLE),
        .bit_en_o (bit_en)
    );

    assign start_acc  = (state_q == ST_IDLE) && start && (frame_len != '0);
    assign final_word = (fetched_q == len_q) && !wbuf_full_q;
    assign field_end  = bit_en && last_bit;
    assign boundary   = field_end &&
                        ((state_q == ST_LEN) || ((state_q == ST_PAY) && !final_word));
    assign load       = s_valid && s_ready;
    assign shifting   = (state_q == ST_PRE) || (state_q == ST_LEN) || (state_q == ST_PAY);

    always_comb begin
        last_bit = 1'b0;
        case (state_q)
            ST_PRE:  last_bit = (cnt_q == CNT_W'(PRE_LEN - 1));
            ST_LEN:  last_bit = (cnt_q == CNT_W'(LEN_W - 1));
            ST_PAY:  last_bit = (cnt_q == CNT_W'(DATA_W - 1));
            ST_PAR:  last_bit = 1'b1;
            ST_TAIL: last_bit = (cnt_q == CNT_W'(TAIL_BITS - 1));
            default: last_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A missing word at any boundary skips straight to the tail, so parity is omitted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_acc) state_d = ST_PRE;
            ST_PRE:  if (field_end) state_d = ST_LEN;
            ST_LEN:  if (field_end) state_d = wbuf_full_q ? ST_PAY : ST_TAIL;
            ST_PAY: begin
                if (boundary) begin
                    state_d = wbuf_full_q ? ST_PAY : ST_TAIL;
                end else if (field_end) begin
                    state_d = ST_PAR;
                end
            end
            ST_PAR:  if (field_end) state_d = ST_TAIL;
            ST_TAIL: if (field_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        enc_reset = (state_q == ST_IDLE);
        s_ready   = busy && !wbuf_full_q && (fetched_q < len_q);
        done      = field_end && (state_q == ST_TAIL);
        underrun  = boundary && !wbuf_full_q;
    end

    assign bit_o = bit_q;

    always_comb begin
        len_d       = len_q;
        fetched_d   = fetched_q;
        wbuf_d      = wbuf_q;
        wbuf_full_d = wbuf_full_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        par_d       = par_q;
        bit_d       = bit_q;
        if (start_acc) begin
            len_d       = frame_len;
            fetched_d   = '0;
            wbuf_full_d = 1'b0;
            cnt_d       = '0;
            par_d       = 1'b0;
            sh_d        = SH_W'(PRE_PAT) << (SH_W - PRE_LEN);
            bit_d       = PRE_PAT[PRE_LEN-1];
        end else if (bit_en) begin
            if (state_q == ST_PAY) begin
                par_d = par_q ^ bit_q;
            end
            if (field_end) begin
                cnt_d = '0;
                case (state_d)
                    ST_LEN: begin
                        sh_d  = SH_W'(len_q) << (SH_W - LEN_W);
                        bit_d = len_q[LEN_W-1];
                    end
                    ST_PAY: begin
                        sh_d        = SH_W'(wbuf_q) << (SH_W - DATA_W);
                        bit_d       = wbuf_q[DATA_W-1];
                        wbuf_full_d = 1'b0;
                    end
                    ST_PAR:  bit_d = par_q ^ bit_q;
                    default: bit_d = 1'b0;
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
                sh_d  = sh_q << 1;
                bit_d = shifting ? sh_q[SH_W-2] : 1'b0;
            end
        end
        // s_ready is low while the buffer is full, so this never collides with a drain.
        if (load) begin
            wbuf_d      = s_data;
            wbuf_full_d = 1'b1;
            fetched_d   = fetched_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            fetched_q   <= '0;
            wbuf_full_q <= 1'b0;
            bit_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            fetched_q   <= fetched_d;
            wbuf_full_q <= wbuf_full_d;
            bit_q       <= bit_d;
        end
    end

    always_ff @(posedge clk) begin
        len_q  <= len_d;
        wbuf_q <= wbuf_d;
        sh_q   <= sh_d;
        par_q  <= par_d;
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Directed bench for tx_frame_sequencer with BIT_DIV=4: frame contents, pacing,
// underrun, ignored starts, mid-frame reset and back-to-back frames.
module tb_tx_frame_sequencer;

    localparam int DATA_W  = 8;
    localparam int LEN_W   = 4;
    localparam int BIT_DIV = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  frame_len = '0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready, bit_o, bit_en, enc_reset, busy, done, underrun;

    always #5 clk = ~clk;

    tx_frame_sequencer #(
        .DATA_W  (DATA_W),
        .LEN_W   (LEN_W),
        .BIT_DIV (BIT_DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .frame_len (frame_len),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .bit_o     (bit_o),
        .bit_en    (bit_en),
        .enc_reset (enc_reset),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Payload source
    logic [DATA_W-1:0] words [8];
    int   widx = 0;
    int   avail = 0;
    bit   src_on = 0;
    bit   hs_pend = 0;

    always @(posedge clk) begin
        #1;
        if (hs_pend) begin
            widx++;
            hs_pend = 0;
        end
        s_data  = words[widx % 8];
        s_valid = src_on && (widx < avail);
    end

    // Output monitor
    int          cyc = 0;
    int          nbits, busy_cnt, done_cnt, und_cnt, und_at, hs_cnt;
    int          gap_err, done_en_err, sr_err;
    int          rise_cyc, done_cyc, prev_en_cyc;
    logic [63:0] bits;
    bit          busy_prev, hs_prev, enc_after;

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1 && !busy_prev) begin
            rise_cyc    = cyc;
            prev_en_cyc = cyc - 1;
        end
        busy_prev = (busy === 1'b1);
        if (busy === 1'b1) busy_cnt++;
        if (bit_en === 1'b1) begin
            bits = {bits[62:0], bit_o};
            nbits++;
            if (cyc - prev_en_cyc != BIT_DIV) gap_err++;
            prev_en_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (bit_en !== 1'b1) done_en_err++;
        end
        if (underrun === 1'b1) begin
            und_cnt++;
            und_at = nbits;
        end
        if (cyc == done_cyc + 1) enc_after = enc_reset;
        if (hs_prev && s_ready === 1'b1) sr_err++;
        hs_prev = (s_valid && s_ready === 1'b1);
        if (hs_prev) begin
            hs_cnt++;
            hs_pend = 1;
        end
    end

    task automatic clear_mon();
        nbits = 0; busy_cnt = 0; done_cnt = 0; und_cnt = 0; und_at = -1; hs_cnt = 0;
        gap_err = 0; done_en_err = 0; sr_err = 0;
        rise_cyc = -10; done_cyc = -10; prev_en_cyc = 0;
        bits = '0; hs_prev = 0; enc_after = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_src(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int n);
        for (int i = 0; i < 8; i++) words[i] = w0;
        words[1] = w1;
        words[2] = w2;
        avail   = n;
        widx    = 0;
        hs_pend = 0;
        src_on  = 1;
    endtask

    task automatic start_frame(input int len);
        frame_len = LEN_W'(len);
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int d0;
        bit to;
        d0 = done_cnt;
        to = 1;
        for (int i = 0; i < limit; i++) begin
            tick(1);
            if (done_cnt != d0) begin
                to = 0;
                break;
            end
        end
        check_val({tag, "_timeout"}, 64'(to), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) words[i] = '0;
        clear_mon();
        tick(4);
        check_val("reset_outs", 64'({s_ready, bit_o, bit_en, enc_reset, busy, done, underrun}),
                  64'(7'b0001000));
        reset = 1'b0;
        tick(2);

        // 1: single word C3
        clear_mon();
        set_src(8'hC3, 8'hC3, 8'hC3, 8);
        start_frame(1);
        wait_done("t1", 300);
        tick(2);
        check_val("t1_bits", bits, 64'(23'b10101011_0001_11000011_0_00));
        check_val("t1_nbits", 64'(nbits), 64'd23);
        check_val("t1_busy", 64'(busy_cnt), 64'd92);
        check_val("t1_gap", 64'(gap_err), 64'd0);
        check_val("t1_done", 64'(done_cnt), 64'd1);
        check_val("t1_done_en", 64'(done_en_err), 64'd0);
        check_val("t1_hs", 64'(hs_cnt), 64'd1);
        check_val("t1_und", 64'(und_cnt), 64'd0);
        check_val("t1_encrst", 64'(enc_reset), 64'd1);

        // 2: three words, parity 1, mid-frame start ignored
        clear_mon();
        set_src(8'h01, 8'h02, 8'h04, 3);
        start_frame(3);
        tick(40);
        start_frame(5);
        wait_done("t2", 400);
        tick(10);
        check_val("t2_bits", bits,
                  64'(39'b10101011_0011_00000001_00000010_00000100_1_00));
        check_val("t2_nbits", 64'(nbits), 64'd39);
        check_val("t2_busy", 64'(busy_cnt), 64'd156);
        check_val("t2_hs", 64'(hs_cnt), 64'd3);
        check_val("t2_rdy_full", 64'(sr_err), 64'd0);
        check_val("t2_gap", 64'(gap_err), 64'd0);
        check_val("t2_done", 64'(done_cnt), 64'd1);

        // 3: underrun at the second word boundary
        clear_mon();
        set_src(8'hA5, 8'h00, 8'h00, 1);
        start_frame(2);
        wait_done("t3", 400);
        tick(3);
        check_val("t3_bits", bits, 64'(22'b10101011_0010_10100101_00));
        check_val("t3_nbits", 64'(nbits), 64'd22);
        check_val("t3_und", 64'(und_cnt), 64'd1);
        check_val("t3_und_at", 64'(und_at), 64'd20);
        check_val("t3_busy", 64'(busy_cnt), 64'd88);
        check_val("t3_done", 64'(done_cnt), 64'd1);
        check_val("t3_idle", 64'({enc_reset, busy}), 64'(2'b10));

        // 4: zero-length start ignored
        clear_mon();
        src_on = 0;
        start_frame(0);
        tick(10);
        check_val("t4_busy", 64'(busy_cnt), 64'd0);
        check_val("t4_encrst", 64'(enc_reset), 64'd1);

        // 5: reset during payload, then a clean frame
        clear_mon();
        set_src(8'h11, 8'h22, 8'h00, 2);
        start_frame(2);
        begin
            bit to;
            to = 1;
            for (int i = 0; i < 200; i++) begin
                tick(1);
                if (nbits >= 14) begin
                    to = 0;
                    break;
                end
            end
            check_val("t5_pay_timeout", 64'(to), 64'd0);
        end
        reset = 1'b1;
        tick(1);
        check_val("t5_rst_outs", 64'({s_ready, bit_o, bit_en, enc_reset, busy, done, underrun}),
                  64'(7'b0001000));
        reset = 1'b0;
        tick(20);
        check_val("t5_no_done", 64'(done_cnt), 64'd0);
        check_val("t5_idle", 64'(busy), 64'd0);
        clear_mon();
        set_src(8'hC3, 8'hC3, 8'hC3, 8);
        start_frame(1);
        wait_done("t5b", 300);
        tick(2);
        check_val("t5_bits", bits, 64'(23'b10101011_0001_11000011_0_00));
        check_val("t5_busy", 64'(busy_cnt), 64'd92);

        // 6: start held high, back-to-back frames
        clear_mon();
        set_src(8'hC3, 8'hC3, 8'hC3, 8);
        frame_len = LEN_W'(1);
        start = 1'b1;
        wait_done("t6a", 300);
        begin
            bit to;
            to = 1;
            for (int i = 0; i < 20; i++) begin
                if (rise_cyc > done_cyc) begin
                    to = 0;
                    break;
                end
                tick(1);
            end
            check_val("t6_rise_timeout", 64'(to), 64'd0);
        end
        start = 1'b0;
        check_val("t6_gap_after_done", 64'(rise_cyc - done_cyc), 64'd2);
        check_val("t6_encrst_idle", 64'(enc_after), 64'd1);
        wait_done("t6b", 300);
        tick(2);
        check_val("t6_done", 64'(done_cnt), 64'd2);
        check_val("t6_nbits", 64'(nbits), 64'd46);
        check_val("t6_busy", 64'(busy_cnt), 64'd184);
        check_val("t6_hs", 64'(hs_cnt), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
